uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit sink (Avalon-ST data/valid/ready toward the RS-232 core) among NUM_REQ independent byte-stream requesters.
- Grants are round-robin and packet-locked: a requester keeps the sink until its byte flagged last is accepted.
- A stall watchdog revokes the grant from a requester that goes silent mid-packet.
- Sits between the application senders (counters, status reporters, echo logic) and the UART core's to_uart_* sink.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width of each stream
- TIMEOUT_CYC, 1000, idle cycles tolerated mid-packet before the grant is revoked; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is the final byte of its packet
- req_ready  out  NUM_REQ  per-requester accept
- tx_data  out  DATA_W  to UART sink data
- tx_valid  out  1  to UART sink valid
- tx_ready  in  1  from UART sink ready
- grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high while in SEND
- timeout_pulse  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, busy 0, timeout_pulse 0, stall counter 0; tx_valid 0 and req_ready all 0 (combinational from state).
- States:
  - IDLE: no grant; tx_valid=0; req_ready=0.
  - SEND: grant g; tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready; req_ready for all other requesters is 0.
  - SEND is a pure combinational pass-through: zero added latency per byte.
- IDLE -> SEND:
  - Triggered when any req_valid bit is high.
  - Winner is the first set bit scanning from rr_ptr upward, wrapping from NUM_REQ-1 to 0.
  - Decision is registered into grant_id; first byte is presented on tx_* the cycle after the request is seen (1-cycle arbitration latency).
- SEND -> IDLE, normal: on the cycle where req_valid[g] & req_last[g] & tx_ready. rr_ptr <= (g+1) mod NUM_REQ. Exactly one bubble cycle before the next grant.
- SEND -> IDLE, timeout:
  - Stall counter clears on any accepted beat and on entering SEND.
  - It increments on each SEND cycle with req_valid[g]=0; cycles with valid high and ready low do not count (UART backpressure is never a timeout).
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC: go IDLE, pulse timeout_pulse for one cycle, rr_ptr <= (g+1) mod NUM_REQ.
  - tx_valid is already 0 at that point, so no Avalon beat is withdrawn.
- Valid discipline: once tx_valid is asserted it follows the requester. Requesters must hold valid and data until ready, so a beat is never withdrawn.
- Simultaneous requests: exactly one is granted; the others see req_ready=0 and hold.
- Single requester: back-to-back packets from the same requester still incur one IDLE bubble between them.
- Packet length: unlimited.
- Counter width: clog2(TIMEOUT_CYC+1), saturating not needed (exits at terminal value).
- Reset mid-packet: tx_valid and req_ready drop immediately (async). The partial packet is abandoned; the UART core resets on the same reset net.
- busy = (state==SEND), registered.
- grant_id holds the last winner while in IDLE.

Decomposition:
- Shared package uart_arb_pkg:
  - state enum {IDLE, SEND}
  - function for grant index width, clog2(NUM_REQ)
  - default DATA_W constant
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Reused by future TX/RX sharing blocks.
- The FSM, watchdog and muxing stay in uart_tx_arbiter.

Test Plan:
- Single packet: req 0 sends 0x41,0x42,0x43(last) with tx_ready=1 -> tx_valid rises 1 cycle after req_valid; three beats on consecutive cycles; busy falls the cycle after 0x43; rr_ptr=1.
- Contention: req 1 and req 3 both valid at reset exit with 2-byte packets -> req 1 served first, one IDLE bubble, then req 3; req_ready[3]=0 throughout req 1's packet.
- Backpressure: tx_ready low 20 cycles mid-packet with TIMEOUT_CYC=10 -> no timeout_pulse; data held stable; packet completes intact.
- Watchdog: req 2 sends one non-last byte, then drops valid for 10 cycles (TIMEOUT_CYC=10) -> timeout_pulse for exactly one cycle, busy=0, and a waiting req 3 is granted next.
- Wrap: rr_ptr=3 (NUM_REQ=4), req 0 and req 3 valid -> req 3 wins; afterwards rr_ptr=0 and req 0 wins.
- Reset mid-packet: assert rst asynchronously during beat 2 of 4 -> tx_valid and req_ready go 0 immediately; after release state is IDLE, rr_ptr=0, grant_id=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg : shared types and helpers for the UART TX sharing blocks
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W = 8;

  // Index width for n requesters; never below one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// uart_tx_arbiter_if : requester streams, UART sink and arbiter status
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  localparam int GW = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [GW-1:0]             grant_id;
  logic                      busy;
  logic                      timeout_pulse;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set bit from ptr upward
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic found;

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : packet-locked round-robin sharing of one UART TX sink
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Exit happens on the idle cycle that would take the count to TIMEOUT_CYC.
  localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          tpulse_q, tpulse_d;
  logic [CW-1:0] stall_q, stall_d;

  logic [GW-1:0] w_winner;
  logic          w_any;
  logic          w_g_valid;
  logic          w_g_last;
  logic [GW-1:0] w_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .winner  (w_winner),
    .any_req (w_any)
  );

  assign w_g_valid = bus.req_valid[grant_q];
  assign w_g_last  = bus.req_last[grant_q];
  assign w_next    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    tpulse_d = 1'b0;
    stall_d  = stall_q;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          state_d = SEND;
          grant_d = w_winner;
          stall_d = '0;
        end
      end
      SEND: begin
        if (w_g_valid && bus.tx_ready) begin
          stall_d = '0;
          if (w_g_last) begin
            state_d  = IDLE;
            rr_ptr_d = w_next;
          end
        end else if (!w_g_valid && (TIMEOUT_CYC != 0)) begin
          // Backpressure (valid high, ready low) deliberately never counts.
          if (stall_q == STALL_LAST) begin
            state_d  = IDLE;
            rr_ptr_d = w_next;
            tpulse_d = 1'b1;
            stall_d  = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      tpulse_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      tpulse_q <= tpulse_d;
      stall_q  <= stall_d;
    end
  end

  // Pass-through from the granted requester; gated only by the current state.
  assign bus.tx_valid      = (state_q == SEND) && w_g_valid;
  assign bus.tx_data       = bus.req_data[int'(grant_q) * DATA_W +: DATA_W];
  assign bus.grant_id      = grant_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_pulse = tpulse_q;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign bus.req_ready[i] = (state_q == SEND) && (grant_q == GW'(i)) && bus.tx_ready;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : directed and randomized checks against a packet-order model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int tp_cnt = 0;
  int m_ptr  = 0;
  logic [8:0]  mem [NR][128];
  int          head [NR];
  int          tail [NR];
  logic [10:0] exp_q [$];
  logic        tx_rdy  = 1'b1;
  logic        rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      if (head[i] != tail[i]) begin
        v[i] = 1'b1;
        l[i] = mem[i][head[i]][8];
        d[i*DW +: DW] = mem[i][head[i]][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = rnd_rdy ? ($urandom_range(3) != 0) : tx_rdy;
  endtask

  // Queue a packet of len bytes for requester id (sequential or random bytes).
  task automatic load(input int id, input int len, input int first, input bit rnd, input bit mark_last);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = rnd ? 8'($urandom) : 8'(first + j);
      mem[id][tail[id]] = {(mark_last && (j == len - 1)), b};
      tail[id]++;
    end
  endtask

  // Expected beat order: rotate from the pointer, each requester with data
  // sends one whole packet (or what it has), pointer moves past it.
  task automatic plan();
    int th [NR];
    int w;
    logic [8:0] b;
    for (int i = 0; i < NR; i++) th[i] = head[i];
    for (int n = 0; n < 64; n++) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && th[(m_ptr + k) % NR] != tail[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
      if (w < 0) break;
      do begin
        b = mem[w][th[w]];
        th[w]++;
        exp_q.push_back({2'(w), b});
      end while (!b[8] && th[w] != tail[w]);
      m_ptr = (w + 1) % NR;
    end
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    logic [10:0]   e;
    acc = bus.req_valid & bus.req_ready;
    if (acc != '0) begin
      chk("ready_onehot", $countones(acc), 1);
      chk("tx_handshake", {bus.tx_valid, bus.tx_ready}, 2'b11);
      if (exp_q.size() == 0) begin
        chk("extra_beat", acc, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {bus.grant_id, bus.req_last[bus.grant_id], bus.tx_data}, e);
      end
    end
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
    #1; drive(); #1;
    if (bus.timeout_pulse) tp_cnt++;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", bus.busy, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_timeout", bus.timeout_pulse, 0);
    @(negedge clk) rst = 1'b0;
    tick(); tick();

    // Single packet, one-cycle arbitration latency, back-to-back beats.
    load(0, 3, 8'h41, 1'b0, 1'b1); plan(); drive(); #1;
    chk("sp_latency", bus.tx_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sp_valid", bus.tx_valid, 1);
      chk("sp_data", bus.tx_data, 8'h41 + c);
    end
    tick();
    chk("sp_busy_fall", bus.busy, 0);

    // Contention between requesters 1 and 3.
    load(1, 2, 8'h10, 1'b0, 1'b1); load(3, 2, 8'h30, 1'b0, 1'b1); plan(); drive(); #1;
    tick(); chk("ct_grant1", bus.grant_id, 1); chk("ct_rdy3_a", bus.req_ready[3], 0);
    tick(); chk("ct_rdy3_b", bus.req_ready[3], 0);
    tick(); chk("ct_bubble", {bus.busy, bus.tx_valid}, 0);
    tick(); chk("ct_grant3", {bus.busy, bus.grant_id}, {1'b1, 2'd3});
    drain(20);

    // Long backpressure mid-packet must not trip the watchdog.
    load(0, 4, 8'h50, 1'b0, 1'b1); plan(); drive(); #1;
    tick(); tick();
    tx_rdy = 1'b0; drive(); #1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_hold", {bus.busy, bus.tx_valid, bus.tx_data}, {2'b11, 8'h51});
    end
    tx_rdy = 1'b1;
    drain(20);
    chk("bp_no_timeout", tp_cnt, 0);

    // Watchdog: requester 2 goes silent after a non-last byte, 3 waits.
    load(2, 1, 8'h60, 1'b0, 1'b0); load(3, 1, 8'h70, 1'b0, 1'b1); plan(); drive(); #1;
    tick();
    for (int s = 0; s < TO; s++) begin
      tick();
      chk("wd_hold", {bus.busy, bus.timeout_pulse, bus.tx_valid}, 3'b100);
    end
    tick(); chk("wd_pulse", {bus.busy, bus.timeout_pulse}, 2'b01);
    tick(); chk("wd_regrant", {bus.busy, bus.timeout_pulse, bus.grant_id}, {2'b10, 2'd3});
    drain(20);
    chk("wd_pulse_count", tp_cnt, 1);

    // Wrap: move pointer to 3, then 0 and 3 contend.
    load(2, 1, 8'h80, 1'b0, 1'b1); plan(); drive(); #1; drain(20);
    load(0, 2, 8'h90, 1'b0, 1'b1); load(3, 2, 8'hA0, 1'b0, 1'b1); plan(); drive(); #1;
    tick(); chk("wrap_grant3", bus.grant_id, 3);
    drain(30);

    // Randomized traffic with random sink backpressure.
    rnd_rdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      clear_model();
      for (int i = 0; i < NR; i++) begin
        for (int p = 0; p < int'($urandom_range(2)); p++) begin
          load(i, int'($urandom_range(4, 1)), 0, 1'b1, 1'b1);
        end
      end
      plan(); drive(); #1;
      drain(400);
    end
    rnd_rdy = 1'b0;
    chk("rnd_no_timeout", tp_cnt, 1);

    // Reset mid-packet with the pointer parked at 1.
    load(0, 1, 8'hB0, 1'b0, 1'b1); plan(); drive(); #1; drain(20);
    load(1, 4, 8'hC0, 1'b0, 1'b1); plan(); drive(); #1;
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    chk("rm_tx_valid", bus.tx_valid, 0);
    chk("rm_req_ready", bus.req_ready, 0);
    clear_model(); drive();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rm_state", {bus.busy, bus.grant_id, bus.timeout_pulse}, 0);
    m_ptr = 0;
    load(0, 1, 8'hD0, 1'b0, 1'b1); load(2, 1, 8'hE0, 1'b0, 1'b1); plan(); drive(); #1;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
